// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame packer.
package uart_pkg;

  // Packer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_BYTE = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // First byte of every frame unless overridden at instantiation.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Width needed to index every byte of a frame (SYNC, SEQ, payload, CHK).
  function automatic int byte_idx_width(input int samples_per_frame);
    return $clog2(3 + 2 * samples_per_frame);
  endfunction

endpackage

// File: rtl/uart_sample_fifo.sv
// Synchronous sample FIFO: refuses pushes when full (even alongside a pop),
// ignores pops when empty, pointers wrap at DEPTH.
module uart_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer and occupancy values.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; pointers and count decide which entries are valid.
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Buffers 16-bit samples and emits framed bytes (SYNC, SEQ, MSB/LSB per
// sample, CHK) over the UART TX DV/Active/Done byte handshake.
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int         SAMPLES_PER_FRAME = 4,
  parameter int         FIFO_DEPTH        = 8,
  parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst,
  input  logic                          i_Sample_DV,
  input  logic [15:0]                   i_Sample,
  output logic                          o_Sample_Ready,
  output logic                          o_Drop,
  output logic                          o_TX_DV,
  output logic [7:0]                    o_TX_Byte,
  input  logic                          i_TX_Active,
  input  logic                          i_TX_Done,
  output logic                          o_Frame_Busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int IDX_W    = byte_idx_width(SAMPLES_PER_FRAME);
  localparam int LAST_IDX = 2 + 2 * SAMPLES_PER_FRAME;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d, next_idx;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       chk_q, chk_d;
  logic [15:0]      sample_q, sample_d, pick;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic             load_next;

  logic [15:0]      fifo_rd_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_pop;

  function automatic logic is_payload(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(2)) && (idx < IDX_W'(LAST_IDX));
  endfunction

  uart_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (i_Clock),
    .rst     (i_Rst),
    .push    (i_Sample_DV),
    .wr_data (i_Sample),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_Sample_Ready = !fifo_full;
  assign o_Fifo_Count   = fifo_count;
  assign o_Drop         = drop_q;
  assign o_TX_DV        = tx_dv_q;
  assign o_TX_Byte      = tx_byte_q;
  assign o_Frame_Busy   = busy_q;

  // Frame sequencing: start, byte selection, checksum, sample pop.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    seq_d      = seq_q;
    chk_d      = chk_q;
    sample_d   = sample_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    drop_d     = i_Sample_DV && fifo_full;
    fifo_pop   = 1'b0;
    load_next  = 1'b0;
    next_idx   = byte_idx_q + IDX_W'(1);

    case (state_q)
      ST_IDLE: begin
        if ((fifo_count >= CNT_W'(SAMPLES_PER_FRAME)) && !i_TX_Active) begin
          load_next = 1'b1;
          next_idx  = '0;
          chk_d     = '0;
          busy_d    = 1'b1;
        end
      end
      ST_LOAD_BYTE: begin
        state_d = ST_WAIT_DONE;
        // SYNC and CHK itself are excluded from the running sum.
        if ((byte_idx_q != '0) && (byte_idx_q != IDX_W'(LAST_IDX)))
          chk_d = chk_q + tx_byte_q;
        // The head sample leaves the FIFO as its LSB is strobed.
        fifo_pop = is_payload(byte_idx_q) && byte_idx_q[0] && !fifo_empty;
      end
      ST_WAIT_DONE: begin
        if (i_TX_Done) begin
          if (byte_idx_q == IDX_W'(LAST_IDX)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            seq_d   = seq_q + 8'd1;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // MSB comes straight from the FIFO head (and is captured); LSB from the held copy.
    pick = (is_payload(next_idx) && !next_idx[0]) ? fifo_rd_data : sample_q;
    if (load_next) begin
      state_d    = ST_LOAD_BYTE;
      byte_idx_d = next_idx;
      tx_dv_d    = 1'b1;
      if (next_idx == '0)                      tx_byte_d = SYNC_BYTE;
      else if (next_idx == IDX_W'(1))          tx_byte_d = seq_q;
      else if (next_idx == IDX_W'(LAST_IDX))   tx_byte_d = chk_q;
      else if (!next_idx[0]) begin
        tx_byte_d = pick[15:8];
        sample_d  = pick;
      end else                                 tx_byte_d = pick[7:0];
    end
  end

  // Packer state registers.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      seq_q      <= '0;
      chk_q      <= '0;
      sample_q   <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      seq_q      <= seq_d;
      chk_q      <= chk_d;
      sample_q   <= sample_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with a simple UART TX byte model.
module tb_uart_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_dv = 1'b0;
  logic [15:0] sample = '0;
  logic        tx_active;
  logic        tx_done;
  logic        sample_ready, drop, tx_dv, frame_busy;
  logic [7:0]  tx_byte;
  logic [3:0]  fifo_count;

  typedef enum int {M_OFF, M_AUTO, M_HOLD} tx_mode_e;
  tx_mode_e    mode = M_OFF;

  int          n_checks = 0;
  int          n_pass = 0;
  int          done_req = 0;
  int          done_ack = 0;
  int          dv_viol = 0;
  logic        prev_dv = 1'b0;
  logic [7:0]  got_bytes [$];

  logic [7:0]  exp1 [11] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
  logic [7:0]  exp2 [11] = '{8'hA5, 8'h01, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55};
  logic [7:0]  exp5 [11] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};

  always #5 clk = ~clk;

  uart_frame_packer dut (
    .i_Clock        (clk),
    .i_Rst          (rst),
    .i_Sample_DV    (sample_dv),
    .i_Sample       (sample),
    .o_Sample_Ready (sample_ready),
    .o_Drop         (drop),
    .o_TX_DV        (tx_dv),
    .o_TX_Byte      (tx_byte),
    .i_TX_Active    (tx_active),
    .i_TX_Done      (tx_done),
    .o_Frame_Busy   (frame_busy),
    .o_Fifo_Count   (fifo_count)
  );

  // UART TX model: AUTO answers each DV with Done 10 cycles later,
  // HOLD keeps Active high, OFF only pulses Done on request.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      case (mode)
        M_HOLD: tx_active = 1'b1;
        M_OFF: begin
          tx_active = 1'b0;
          if (done_ack != done_req) begin
            tx_done = 1'b1;
            done_ack++;
          end
        end
        default: begin
          tx_active = 1'b0;
          if (tx_dv) begin
            got_bytes.push_back(tx_byte);
            tx_active = 1'b1;
            repeat (10) @(negedge clk);
            tx_done   = 1'b1;
            tx_active = 1'b0;
          end
        end
      endcase
    end
  end

  // Handshake monitor: DV never while Active, never two cycles in a row.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (tx_dv && tx_active) dv_viol++;
      if (tx_dv && prev_dv) dv_viol++;
      prev_dv = tx_dv;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    sample_dv = 1'b1;
    sample    = v;
    tick();
    sample_dv = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    check({tag, "_dv"},    32'(tx_dv), 0);
    check({tag, "_byte"},  32'(tx_byte), 0);
    check({tag, "_drop"},  32'(drop), 0);
    check({tag, "_busy"},  32'(frame_busy), 0);
    check({tag, "_count"}, 32'(fifo_count), 0);
    check({tag, "_ready"}, 32'(sample_ready), 1);
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n_bytes, input string tag);
    int t = 0;
    while (!((got_bytes.size() >= n_bytes) && !frame_busy) && (t < 500)) begin
      tick();
      t++;
    end
    check({tag, "_frame_done"}, 32'(t < 500), 1);
  endtask

  task automatic manual_done();
    tick();
    done_req++;
    tick();
  endtask

  initial begin
    int base, t, dvs, cycles;

    // Test 1: basic frame, busy span, FIFO drains.
    do_reset("rst1");
    mode = M_AUTO;
    base = got_bytes.size();
    push(16'h1234); push(16'h5678); push(16'h9ABC); push(16'hDEF0);
    t = 0;
    while (!frame_busy && t < 10) begin tick(); t++; end
    cycles = 0;
    while (frame_busy && cycles < 400) begin cycles++; tick(); end
    check("t1_busy_cycles", cycles, 121);
    check("t1_nbytes", got_bytes.size() - base, 11);
    for (int i = 0; i < 11; i++)
      if (base + i < got_bytes.size()) check($sformatf("t1_byte%0d", i), 32'(got_bytes[base + i]), 32'(exp1[i]));
    check("t1_count", 32'(fifo_count), 0);

    // Test 2: partial frame waits; the 4th sample starts it.
    base = got_bytes.size();
    push(16'h1111); push(16'h2222); push(16'h3333);
    dvs = 0;
    repeat (1000) begin tick(); if (tx_dv) dvs++; end
    check("t2_no_dv", dvs, 0);
    check("t2_count3", 32'(fifo_count), 3);
    push(16'h4444);
    dvs = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (tx_dv && dvs == 0) dvs = 1;
    end
    check("t2_start_within_2", dvs, 1);
    wait_frames(base + 11, "t2");
    for (int i = 0; i < 11; i++)
      if (base + i < got_bytes.size()) check($sformatf("t2_byte%0d", i), 32'(got_bytes[base + i]), 32'(exp2[i]));

    // Test 3: 257 zero frames, SEQ wrap, back-to-back start.
    do_reset("rst3");
    base = got_bytes.size();
    for (int i = 0; i < 8; i++) push(16'h0000);
    wait_frames(base + 11, "t3_f0");
    tick();
    check("t3_b2b_dv", 32'(tx_dv), 1);
    for (int f = 1; f < 257; f++) begin
      if (f >= 2) for (int i = 0; i < 4; i++) push(16'h0000);
      wait_frames(base + 11 * (f + 1), "t3");
    end
    for (int f = 0; f < 257; f++) begin
      if (base + 11 * f + 10 < got_bytes.size()) begin
        check($sformatf("t3_seq_f%0d", f), 32'(got_bytes[base + 11 * f + 1]), f % 256);
        check($sformatf("t3_chk_f%0d", f), 32'(got_bytes[base + 11 * f + 10]), f % 256);
      end
    end

    // Test 4: FIFO full, drop pulse, push+pop while full still drops.
    mode = M_OFF;
    do_reset("rst4");
    for (int k = 1; k <= 8; k++) push(16'h0101 * 16'(k));
    check("t4_count8", 32'(fifo_count), 8);
    check("t4_ready0", 32'(sample_ready), 0);
    check("t4_nodrop", 32'(drop), 0);
    push(16'h0909);
    check("t4_drop", 32'(drop), 1);
    check("t4_count_after_drop", 32'(fifo_count), 8);
    tick();
    check("t4_drop_pulse", 32'(drop), 0);
    manual_done(); manual_done(); manual_done();
    check("t4_lsb_dv", 32'(tx_dv), 1);
    check("t4_lsb_byte", 32'(tx_byte), 32'h01);
    push(16'hBEEF);
    check("t4_pushpop_drop", 32'(drop), 1);
    check("t4_pushpop_count", 32'(fifo_count), 7);
    check("t4_pushpop_ready", 32'(sample_ready), 1);

    // Test 5: reset after the 5th byte aborts the frame; next frame uses SEQ 00.
    mode = M_AUTO;
    do_reset("rst5a");
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC); push(16'hDDDD);
    dvs = 0; t = 0;
    while (dvs < 5 && t < 500) begin tick(); t++; if (tx_dv) dvs++; end
    check("t5_fifth_dv", dvs, 5);
    do_reset("rst5b");
    base = got_bytes.size();
    push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
    wait_frames(base + 11, "t5");
    for (int i = 0; i < 11; i++)
      if (base + i < got_bytes.size()) check($sformatf("t5_byte%0d", i), 32'(got_bytes[base + i]), 32'(exp5[i]));

    // Test 6: Active held high blocks the start; SYNC follows its fall.
    mode = M_HOLD;
    tick();
    base = got_bytes.size();
    push(16'h00FF); push(16'h00FF); push(16'h00FF); push(16'h00FF);
    dvs = 0;
    repeat (20) begin tick(); if (tx_dv) dvs++; end
    check("t6_hold_no_dv", dvs, 0);
    mode = M_AUTO;
    tick();
    check("t6_sync_dv", 32'(tx_dv), 1);
    check("t6_sync_byte", 32'(tx_byte), 32'hA5);
    wait_frames(base + 11, "t6");
    if (base + 1 < got_bytes.size()) check("t6_seq", 32'(got_bytes[base + 1]), 32'h01);

    check("dv_handshake_violations", dv_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
